// File: rtl/mem_cmd_bridge.sv
// mem_cmd_bridge
//
// Turns a byte-oriented host command stream into single-cycle accesses on a
// 16-bit synchronous RAM. It also streams read data back to the host as bytes.
//
// Command format (host -> bridge):
//   'W' (0x57) ADDR_H ADDR_L LEN  D0_H D0_L D1_H D1_L ...   write LEN words
//   'R' (0x52) ADDR_H ADDR_L LEN                            read LEN words
//   LEN = 0x00 means 256 words. Any other byte seen in IDLE is dropped.
//   The address increments per word and wraps modulo VECTOR_LENGTH.
//
// Handshake: each byte stream is a valid/ready pair. A byte moves on the
// rising edge where valid and ready are both high, and on no other edge.
// Once in_valid_o is raised, in_data_o holds its value until that edge.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   out_data_i/out_valid_i/out_ready_o  host -> bridge command/data bytes
//   in_data_o/in_valid_o/in_ready_i     bridge -> host read-back bytes
//   ram_clke_o     one-cycle RAM access strobe
//   ram_we_o       1 = write, 0 = read (only meaningful with ram_clke_o)
//   ram_addr_o     RAM word address (current address register)
//   ram_mask_o     bit mask, 0 = bit written; always full-word writes
//   ram_wdata_o    write word
//   ram_rdata_i    read word, valid the cycle after a read strobe
//   busy_o         high whenever the FSM is not in IDLE
module mem_cmd_bridge #(
  parameter int VECTOR_LENGTH = 512,
  parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic                  ram_clke_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [15:0]           ram_mask_o,
  output logic [15:0]           ram_wdata_o,
  input  logic [15:0]           ram_rdata_i,
  output logic                  busy_o
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LENGTH - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR_H  = 4'd1,
    ADDR_L  = 4'd2,
    LEN     = 4'd3,
    WR_HI   = 4'd4,
    WR_LO   = 4'd5,
    WR_MEM  = 4'd6,
    RD_REQ  = 4'd7,
    RD_WAIT = 4'd8,
    RD_HI   = 4'd9,
    RD_LO   = 4'd10
  } state_t;

  state_t      state, state_next;
  logic [15:0] addr, addr_next;
  logic [8:0]  count, count_next;     // 9 bits so that LEN=0x00 can mean 256
  logic [15:0] hold, hold_next;
  logic [15:0] wdata, wdata_next;
  logic        write_flag, write_next;
  logic        ready_state;

  logic [ADDR_WIDTH-1:0] addr_word;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  addr_unused;

  // The address register is 16 bits wide. Only the low ADDR_WIDTH bits reach
  // the RAM; the upper bits are captured from the host and otherwise ignored.
  assign addr_word   = addr[ADDR_WIDTH-1:0];
  assign addr_unused = ^addr;

  // Explicit wrap so that a non-power-of-two depth also wraps at
  // VECTOR_LENGTH-1 instead of at 2**ADDR_WIDTH-1.
  assign addr_inc = (addr_word == LAST_ADDR) ? '0 : addr_word + ADDR_WIDTH'(1);

  // State register and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      addr       <= 16'h0000;
      count      <= 9'd0;
      hold       <= 16'h0000;
      wdata      <= 16'h0000;
      write_flag <= 1'b0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      count      <= count_next;
      hold       <= hold_next;
      wdata      <= wdata_next;
      write_flag <= write_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next  = state;
    addr_next   = addr;
    count_next  = count;
    hold_next   = hold;
    wdata_next  = wdata;
    write_next  = write_flag;
    ready_state = 1'b0;
    in_valid_o  = 1'b0;
    in_data_o   = 8'h00;
    ram_clke_o  = 1'b0;
    ram_we_o    = 1'b0;

    case (state)
      IDLE: begin
        ready_state = 1'b1;
        if (out_valid_i) begin
          if (out_data_i == CMD_WRITE) begin
            write_next = 1'b1;
            state_next = ADDR_H;
          end else if (out_data_i == CMD_READ) begin
            write_next = 1'b0;
            state_next = ADDR_H;
          end
          // Any other byte is accepted and dropped.
        end
      end

      ADDR_H: begin
        ready_state = 1'b1;
        if (out_valid_i) begin
          addr_next  = {out_data_i, addr[7:0]};
          state_next = ADDR_L;
        end
      end

      ADDR_L: begin
        ready_state = 1'b1;
        if (out_valid_i) begin
          addr_next  = {addr[15:8], out_data_i};
          state_next = LEN;
        end
      end

      LEN: begin
        ready_state = 1'b1;
        if (out_valid_i) begin
          count_next = (out_data_i == 8'h00) ? 9'd256 : {1'b0, out_data_i};
          state_next = write_flag ? WR_HI : RD_REQ;
        end
      end

      WR_HI: begin
        ready_state = 1'b1;
        if (out_valid_i) begin
          wdata_next = {out_data_i, wdata[7:0]};
          state_next = WR_LO;
        end
      end

      WR_LO: begin
        ready_state = 1'b1;
        if (out_valid_i) begin
          wdata_next = {wdata[15:8], out_data_i};
          state_next = WR_MEM;
        end
      end

      WR_MEM: begin
        ram_clke_o = 1'b1;
        ram_we_o   = 1'b1;
        count_next = count - 9'd1;
        addr_next  = 16'(addr_inc);
        state_next = (count == 9'd1) ? IDLE : WR_HI;
      end

      RD_REQ: begin
        ram_clke_o = 1'b1;
        state_next = RD_WAIT;
      end

      // The RAM returns data one cycle after the strobe. Capture it here so
      // the host can stall without the RAM output having to stay stable.
      RD_WAIT: begin
        hold_next  = ram_rdata_i;
        state_next = RD_HI;
      end

      RD_HI: begin
        in_valid_o = 1'b1;
        in_data_o  = hold[15:8];
        if (in_ready_i) begin
          state_next = RD_LO;
        end
      end

      RD_LO: begin
        in_valid_o = 1'b1;
        in_data_o  = hold[7:0];
        if (in_ready_i) begin
          count_next = count - 9'd1;
          addr_next  = 16'(addr_inc);
          state_next = (count == 9'd1) ? IDLE : RD_REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ready is forced low while reset is held. Every other output is already
  // quiet in IDLE, and the asynchronous reset forces the FSM into IDLE.
  assign out_ready_o = ready_state & ~rst_i;
  assign ram_addr_o  = addr_word;
  assign ram_mask_o  = 16'h0000;
  assign ram_wdata_o = wdata;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_mem_cmd_bridge.sv
`timescale 1ns/1ps
module tb_mem_cmd_bridge;

  localparam int VL = 512;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [7:0]    out_data_i;
  logic          out_valid_i;
  logic          out_ready_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready_i;
  logic          ram_clke_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [15:0]   ram_mask_o;
  logic [15:0]   ram_wdata_o;
  logic [15:0]   ram_rdata_i = 16'h0000;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_cmd_bridge #(.VECTOR_LENGTH(VL), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .ram_clke_o  (ram_clke_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_mask_o  (ram_mask_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .busy_o      (busy_o)
  );

  // RAM model, cycle counter and strobe log
  logic [15:0] mem [0:VL-1];
  logic        ram_init = 1'b1;
  int          cyc = 0;
  int          rd_cyc = 0;
  int          rd_strobes = 0;
  int          wr_strobes = 0;
  logic [47:0] act_q[$];   // {addr16, data, mask} of each write strobe
  logic [31:0] exp_q[$];   // {addr16, data} expected writes

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_init) begin
      for (int i = 0; i < VL; i++) mem[i] <= 16'h0000;
    end else if (ram_clke_o) begin
      if (ram_we_o) begin
        mem[ram_addr_o] <= ram_wdata_o;
        wr_strobes      <= wr_strobes + 1;
        act_q.push_back({7'b0, ram_addr_o, ram_wdata_o, ram_mask_o});
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
        rd_strobes  <= rd_strobes + 1;
        rd_cyc      <= cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks (each starts and ends 1 ns after a rising edge)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %h not accepted, out_ready_o=%b required 1", b, out_ready_o);
    end
    @(posedge clk); #1;
    out_valid_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al,
                          input logic [7:0] len);
    send_byte(c);
    send_byte(ah);
    send_byte(al);
    send_byte(len);
  endtask

  task automatic recv_byte(output logic [7:0] b, output int c);
    int n = 0;
    in_ready_i = 1'b1;
    while (!in_valid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL recv_timeout: in_valid_o=%b required 1", in_valid_o);
    end
    b = in_data_o;
    c = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy_o=%b required 0", name, busy_o);
    end
  endtask

  // scoreboard: pop expected writes against logged write strobes
  task automatic check_writes(input string name);
    logic [31:0] e;
    logic [47:0] a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act_q.size() == 0) begin
        bad++;
        $display("FAIL %s_wr_missing: no write strobe, required addr=%h data=%h", name, e[31:16], e[15:0]);
      end else begin
        a = act_q.pop_front();
        if (a[47:16] !== e) begin
          bad++;
          $display("FAIL %s_wr: addr=%h data=%h required addr=%h data=%h",
                   name, a[47:32], a[31:16], e[31:16], e[15:0]);
        end
        total++;
        if (a[15:0] !== 16'h0000) begin
          bad++;
          $display("FAIL %s_mask: mask=%h required 0000", name, a[15:0]);
        end
      end
    end
    total++;
    if (act_q.size() != 0) begin
      bad++;
      $display("FAIL %s_wr_extra: %0d extra write strobes, required 0", name, act_q.size());
      act_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    rst_i = 1'b0; out_valid_i = 1'b0; out_data_i = 8'h00; in_ready_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_ready_o !== 1'b0) begin bad++; $display("FAIL rst_out_ready: %b required 0", out_ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: %b required 0", busy_o); end
    total++; if (ram_clke_o !== 1'b0) begin bad++; $display("FAIL rst_clke: %b required 0", ram_clke_o); end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL rst_we: %b required 0", ram_we_o); end
    total++; if (ram_mask_o !== 16'h0000) begin bad++; $display("FAIL rst_mask: %h required 0000", ram_mask_o); end
    total++; if (in_valid_o !== 1'b0) begin bad++; $display("FAIL rst_in_valid: %b required 0", in_valid_o); end
    total++; if (in_data_o !== 8'h00) begin bad++; $display("FAIL rst_in_data: %h required 00", in_data_o); end
    total++; if (ram_addr_o !== 9'h000) begin bad++; $display("FAIL rst_addr: %h required 000", ram_addr_o); end
    ram_init = 1'b0;
    rst_i = 1'b0;
    #1;
    total++; if (out_ready_o !== 1'b1) begin bad++; $display("FAIL rst_release_ready: %b required 1", out_ready_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int w0 = wr_strobes;
    exp_q.push_back({16'h0100, 16'hABCD});
    exp_q.push_back({16'h0101, 16'h1234});
    send_cmd(8'h57, 8'h01, 8'h00, 8'h02);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h12); send_byte(8'h34);
    wait_idle("write");
    total++;
    if (wr_strobes - w0 != 2) begin
      bad++; $display("FAIL write_strobes: %0d required 2", wr_strobes - w0);
    end
    check_writes("write");
  endtask

  task automatic test_read(input logic [7:0] ah, input logic [7:0] al,
                           input logic [31:0] exp_bytes, input string name);
    logic [7:0] b;
    int c;
    int c0 = 0;
    int r0 = rd_strobes;
    send_cmd(8'h52, ah, al, 8'h02);
    for (int k = 0; k < 4; k++) begin
      recv_byte(b, c);
      total++;
      if (b !== exp_bytes[31-8*k -: 8]) begin
        bad++; $display("FAIL %s_byte%0d: %h required %h", name, k, b, exp_bytes[31-8*k -: 8]);
      end
      if (k == 0) begin
        c0 = c;
        total++;
        if (c - rd_cyc != 2) begin
          bad++; $display("FAIL %s_latency: %0d cycles required 2", name, c - rd_cyc);
        end
      end
      if (k == 2) begin
        total++;
        if (c - c0 != 4) begin
          bad++; $display("FAIL %s_throughput: %0d cycles/word required 4", name, c - c0);
        end
      end
    end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL %s_end_busy: %b required 0", name, busy_o); end
    total++;
    if (rd_strobes - r0 != 2) begin
      bad++; $display("FAIL %s_rd_strobes: %0d required 2", name, rd_strobes - r0);
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back({16'h01FF, 16'h1122});
    exp_q.push_back({16'h0000, 16'h3344});
    send_cmd(8'h57, 8'h01, 8'hFF, 8'h02);
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    wait_idle("wrap_write");
    check_writes("wrap_write");
    test_read(8'h01, 8'hFF, 32'h11223344, "wrap_read");
  endtask

  task automatic test_stall();
    logic [31:0] exp_bytes = 32'hABCD1234;
    logic [7:0]  e;
    int r0 = rd_strobes;
    int n;
    in_ready_i = 1'b0;
    send_cmd(8'h52, 8'h01, 8'h00, 8'h02);
    for (int k = 0; k < 4; k++) begin
      e = exp_bytes[31-8*k -: 8];
      n = 0;
      while (!in_valid_o && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      total++;
      if (in_valid_o !== 1'b1 || in_data_o !== e) begin
        bad++; $display("FAIL stall_byte%0d: valid=%b data=%h required 1/%h", k, in_valid_o, in_data_o, e);
      end
      for (int s = 0; s < 2; s++) begin
        @(posedge clk); #1;
        total++;
        if (in_valid_o !== 1'b1 || in_data_o !== e || ram_clke_o !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold%0d: valid=%b data=%h clke=%b required 1/%h/0",
                   k, in_valid_o, in_data_o, ram_clke_o, e);
        end
      end
      in_ready_i = 1'b1;
      @(posedge clk); #1;
      in_ready_i = 1'b0;
    end
    wait_idle("stall");
    total++;
    if (rd_strobes - r0 != 2) begin
      bad++; $display("FAIL stall_rd_strobes: %0d required 2", rd_strobes - r0);
    end
  endtask

  task automatic test_discard_256();
    logic [7:0]  b;
    logic [15:0] w;
    int c;
    int r0;
    send_byte(8'h00);
    total++;
    if (busy_o !== 1'b0 || out_ready_o !== 1'b1) begin
      bad++; $display("FAIL discard_idle: busy=%b ready=%b required 0/1", busy_o, out_ready_o);
    end
    r0 = rd_strobes;
    send_cmd(8'h52, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 512; i++) begin
      recv_byte(b, c);
      // only word 0 was written (3344 by the wrap test); the rest are zero
      w = (i < 2) ? 16'h3344 : 16'h0000;
      total++;
      if (b !== ((i % 2 == 0) ? w[15:8] : w[7:0])) begin
        bad++;
        $display("FAIL len256_byte%0d: %h required %h", i, b, (i % 2 == 0) ? w[15:8] : w[7:0]);
      end
    end
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL len256_end_busy: %b required 0", busy_o); end
    total++;
    if (rd_strobes - r0 != 256) begin
      bad++; $display("FAIL len256_rd_strobes: %0d required 256", rd_strobes - r0);
    end
    total++;
    if (in_valid_o !== 1'b0) begin bad++; $display("FAIL len256_in_valid: %b required 0", in_valid_o); end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_strobes;
    send_cmd(8'h57, 8'h00, 8'h10, 8'h01);
    send_byte(8'hAA);
    total++;
    if (busy_o !== 1'b1 || out_ready_o !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: busy=%b ready=%b required 1/1", busy_o, out_ready_o);
    end
    out_data_i = 8'hBB;
    rst_i = 1'b1;
    #1;
    total++;
    if (busy_o !== 1'b0 || out_ready_o !== 1'b0 || ram_clke_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: busy=%b ready=%b clke=%b required 0/0/0", busy_o, out_ready_o, ram_clke_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    total++;
    if (busy_o !== 1'b0 || out_ready_o !== 1'b1) begin
      bad++; $display("FAIL midrst_release: busy=%b ready=%b required 0/1", busy_o, out_ready_o);
    end
    @(posedge clk); #1;
    total++;
    if (wr_strobes != w0) begin
      bad++; $display("FAIL midrst_no_write: %0d strobes required 0", wr_strobes - w0);
    end
    // a fresh command after the abort starts from a clean state
    exp_q.push_back({16'h0020, 16'h5AA5});
    send_cmd(8'h57, 8'h00, 8'h20, 8'h01);
    send_byte(8'h5A); send_byte(8'hA5);
    wait_idle("post_rst");
    check_writes("post_rst");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(8'h01, 8'h00, 32'hABCD1234, "read");
    test_wrap();
    test_stall();
    test_discard_256();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_cmd_bridge.md
MEM_CMD_BRIDGE -- requirements
Module: mem_cmd_bridge

Interface
REQ-001 Parameter VECTOR_LENGTH, default 512, SHALL set the RAM depth in 16-bit words.
REQ-002 Parameter ADDR_WIDTH, default ceil_log2(VECTOR_LENGTH), SHALL set the RAM address width.
REQ-003 Clocking SHALL use one clock; reset is asynchronous and active-high:
- clk_i  in  1  sole clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
REQ-004 Byte-stream and RAM ports SHALL be:
- out_data_i  in  8  command/data byte from the host.
- out_valid_i  in  1  out_data_i valid.
- out_ready_o  out  1  bridge accepts a byte.
- in_data_o  out  8  read-back byte to the host.
- in_valid_o  out  1  in_data_o valid.
- in_ready_i  in  1  host accepts in_data_o.
- ram_clke_o  out  1  RAM clock enable, one-cycle access strobe.
- ram_we_o  out  1  1 = write, 0 = read.
- ram_addr_o  out  ADDR_WIDTH  RAM word address.
- ram_mask_o  out  16  RAM bit mask; 0 = bit written.
- ram_wdata_o  out  16  RAM write word.
- ram_rdata_i  in  16  RAM read word; valid the cycle after a read strobe.
- busy_o  out  1  high whenever state is not IDLE.

Function
REQ-005 A byte transfer SHALL occur on the rising edge where valid and ready are both high; no other edge transfers a byte.
REQ-006 FSM states SHALL be: IDLE, ADDR_H, ADDR_L, LEN, WR_HI, WR_LO, WR_MEM, RD_REQ, RD_WAIT, RD_HI, RD_LO.
REQ-007 out_ready_o SHALL be 1 in IDLE, ADDR_H, ADDR_L, LEN, WR_HI and WR_LO, and 0 in all other states.
REQ-008 In IDLE, byte 0x57 ('W') SHALL set the write flag and move to ADDR_H; 0x52 ('R') SHALL clear it and move to ADDR_H; any other byte SHALL be consumed and discarded, staying in IDLE.
REQ-009 ADDR_H and ADDR_L SHALL capture the address MSB-first into a 16-bit register; only bits [ADDR_WIDTH-1:0] are used.
REQ-010 The LEN byte SHALL set the word count: N = 1..255, or 256 when the byte is 0x00.
- Write flag set: LEN SHALL go to WR_HI.
- Write flag clear: LEN SHALL go to RD_REQ.
REQ-011 Write path:
- WR_HI SHALL latch wdata[15:8] and go to WR_LO.
- WR_LO SHALL latch wdata[7:0] and go to WR_MEM.
- WR_MEM SHALL assert ram_clke_o=1, ram_we_o=1, ram_mask_o=16'h0000 for exactly one cycle, then decrement the count and increment the address.
- After WR_MEM: count nonzero SHALL return to WR_HI; count zero SHALL go to IDLE.
REQ-012 Read path:
- RD_REQ SHALL assert ram_clke_o=1, ram_we_o=0 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT SHALL capture ram_rdata_i into a holding register, then go to RD_HI.
REQ-013 RD_HI SHALL drive in_valid_o=1 with in_data_o=hold[15:8] until in_ready_i, then go to RD_LO.
- RD_LO SHALL do the same with hold[7:0].
- On the RD_LO handshake, the count SHALL decrement and the address increment; count nonzero SHALL go to RD_REQ, count zero to IDLE.
REQ-014 in_data_o SHALL stay stable while in_valid_o=1 and in_ready_i=0; in_valid_o SHALL be 0 outside RD_HI and RD_LO.
REQ-015 Address increment SHALL wrap modulo VECTOR_LENGTH (VECTOR_LENGTH-1 -> 0) with no error indication.
REQ-016 ram_clke_o SHALL be 0 in every state except WR_MEM and RD_REQ; ram_addr_o SHALL equal the current address register.
REQ-017 Read latency, RD_REQ strobe to first in_valid_o, SHALL be 2 cycles; sustained read throughput with in_ready_i held high SHALL be one word per 4 cycles.
REQ-018 A stalled host (out_valid_i=0 or in_ready_i=0) SHALL hold the state indefinitely with no RAM strobe issued.

Reset
REQ-019 While rst_i=1, all of the following SHALL hold:
- state = IDLE, address = 0, count = 0, hold = 0, wdata = 0.
- ram_clke_o=0, ram_we_o=0, ram_mask_o=16'h0000.
- in_valid_o=0, in_data_o=0, busy_o=0, out_ready_o=0.
REQ-020 Reset asserted mid-command SHALL abort the command immediately with no further RAM strobe; the first rising edge after release SHALL see out_ready_o=1 in IDLE.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Write 57 01 00 02 AB CD 12 34 -> two one-cycle write strobes at addr 0x100 = ABCD and 0x101 = 1234, mask 0000, then IDLE.
- Then read 52 01 00 02, in_ready_i=1 -> in bytes AB CD 12 34; first in_valid_o 2 cycles after the RD_REQ strobe.
- Read 52 01 FF 02 -> reads addr 0x1FF then 0x000 (wrap).
- Read with in_ready_i toggling 1 in 3 -> in_data_o stable while stalled; no extra ram_clke_o pulses.
- Byte 0x00 in IDLE, then 52 00 00 00 -> 0x00 discarded; 256 words = 512 bytes returned, then IDLE.
- rst_i pulsed during WR_LO -> no write strobe; after release busy_o=0, out_ready_o=1.
